// File: rtl/mm_periph_pkg.sv
// Shared definitions for the memory-mapped UART peripheral: register offsets,
// STATUS layout and FSM state encodings.
package mm_periph_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned BAUD_W = 16;
  localparam int unsigned BYTE_W = 8;

  localparam logic [1:0] REG_TXDATA  = 2'd0;
  localparam logic [1:0] REG_STATUS  = 2'd1;
  localparam logic [1:0] REG_BAUDDIV = 2'd2;
  localparam logic [1:0] REG_RXDATA  = 2'd3;

  localparam int unsigned ST_TX_FULL     = 0;
  localparam int unsigned ST_TX_EMPTY    = 1;
  localparam int unsigned ST_TX_BUSY     = 2;
  localparam int unsigned ST_RX_VALID    = 3;
  localparam int unsigned ST_RX_OVERRUN  = 4;
  localparam int unsigned ST_TX_OVERFLOW = 5;

  typedef struct packed {
    logic [15:0] rsvd_hi;
    logic [7:0]  tx_count;
    logic [1:0]  rsvd_lo;
    logic        tx_overflow;
    logic        rx_overrun;
    logic        rx_valid;
    logic        tx_busy;
    logic        tx_empty;
    logic        tx_full;
  } status_reg_t;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} uart_rx_state_t;

  // Occupancy counter width: one extra bit so a full FIFO is representable.
  function automatic int unsigned fifo_count_w(input int unsigned depth);
    return $unsigned($clog2(depth)) + 1;
  endfunction

endpackage

// File: rtl/mm_sync_fifo.sv
// Single-clock FIFO with first-word fall-through read; DEPTH must be a power of 2
// so the pointers wrap naturally.
module mm_sync_fifo
  import mm_periph_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              push,
  input  logic                              pop,
  input  logic [WIDTH-1:0]                  wdata,
  output logic [WIDTH-1:0]                  rdata_c,
  output logic                              full,
  output logic                              empty,
  output logic [fifo_count_w(DEPTH)-1:0]    count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = fifo_count_w(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             do_push;
  logic             do_pop;

  always_comb begin
    do_push  = push && !full_q;
    do_pop   = pop && !empty_q;
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
    full_d   = (count_d == CW'(DEPTH));
    empty_d  = (count_d == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Storage is not reset; contents are only observable through valid pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata_c = mem_q[rd_ptr_q];
  assign full    = full_q;
  assign empty   = empty_q;
  assign count   = count_q;

endmodule

// File: rtl/mm_uart_peripheral.sv
// Memory-mapped UART responder: register file, TX FIFO, baud generator and 8N1 transmitter.
// Define MM_UART_RX_EN to add the UartRx port and the 8N1 receiver.
module mm_uart_peripheral
  import mm_periph_pkg::*;
#(
  parameter int unsigned        TX_FIFO_DEPTH    = 8,
  parameter logic [BAUD_W-1:0]  DEFAULT_BAUD_DIV = 16'd433
) (
  input  logic              CoreClock,
  input  logic              Reset,
  input  logic [DATA_W-1:0] AddressBus,
  input  logic [DATA_W-1:0] DataWriteBus,
  input  logic              WriteAssert,
  input  logic              ReadAssert,
  output logic [DATA_W-1:0] DataReadBus,
  output logic              UartTx
`ifdef MM_UART_RX_EN
  ,
  input  logic              UartRx
`endif
);

  localparam int unsigned CW = fifo_count_w(TX_FIFO_DEPTH);

  logic [1:0]        reg_sel;
  logic              wr_txdata, wr_status, wr_baud;
  logic              fifo_pop, fifo_full, fifo_empty;
  logic [BYTE_W-1:0] fifo_rdata;
  logic [CW-1:0]     fifo_count;

  logic [BAUD_W-1:0] baud_div_q, baud_div_d;
  logic              tx_overflow_q, tx_overflow_d;
  uart_tx_state_t    tx_state_q, tx_state_d;
  logic [BAUD_W-1:0] baud_cnt_q, baud_cnt_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [BYTE_W-1:0] shift_q, shift_d;
  logic              tx_q, tx_d;
  logic              bit_done;

  logic              rx_valid, rx_overrun;
  logic [BYTE_W-1:0] rx_byte;
  status_reg_t       status;

  always_comb begin
    reg_sel   = AddressBus[3:2];
    wr_txdata = WriteAssert && (reg_sel == REG_TXDATA);
    wr_status = WriteAssert && (reg_sel == REG_STATUS);
    wr_baud   = WriteAssert && (reg_sel == REG_BAUDDIV);
  end

  mm_sync_fifo #(.WIDTH(BYTE_W), .DEPTH(TX_FIFO_DEPTH)) u_tx_fifo (
    .clk     (CoreClock),
    .rst     (Reset),
    .push    (wr_txdata),
    .pop     (fifo_pop),
    .wdata   (DataWriteBus[BYTE_W-1:0]),
    .rdata_c (fifo_rdata),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // Register file writes; overflow uses the pre-edge full flag.
  always_comb begin
    baud_div_d    = baud_div_q;
    tx_overflow_d = tx_overflow_q;
    if (wr_baud) baud_div_d = DataWriteBus[BAUD_W-1:0];
    if (wr_status && DataWriteBus[ST_TX_OVERFLOW]) tx_overflow_d = 1'b0;
    if (wr_txdata && fifo_full) tx_overflow_d = 1'b1;
  end

  // Transmit FSM; the baud counter reloads from BAUDDIV at every bit boundary.
  always_comb begin
    tx_state_d = tx_state_q;
    baud_cnt_d = baud_cnt_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    fifo_pop   = 1'b0;
    bit_done   = (baud_cnt_q == '0);
    unique case (tx_state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          shift_d    = fifo_rdata;
          baud_cnt_d = baud_div_q;
          tx_state_d = START;
        end
      end
      START: begin
        if (bit_done) begin
          tx_state_d = DATA;
          bit_idx_d  = 3'd0;
          baud_cnt_d = baud_div_q;
        end else begin
          baud_cnt_d = baud_cnt_q - 16'd1;
        end
      end
      DATA: begin
        if (bit_done) begin
          baud_cnt_d = baud_div_q;
          if (bit_idx_q == 3'd7) begin
            tx_state_d = STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            shift_d   = shift_q >> 1;
          end
        end else begin
          baud_cnt_d = baud_cnt_q - 16'd1;
        end
      end
      STOP: begin
        if (bit_done) begin
          if (!fifo_empty) begin
            fifo_pop   = 1'b1;
            shift_d    = fifo_rdata;
            baud_cnt_d = baud_div_q;
            tx_state_d = START;
          end else begin
            tx_state_d = IDLE;
          end
        end else begin
          baud_cnt_d = baud_cnt_q - 16'd1;
        end
      end
      default: tx_state_d = IDLE;
    endcase

    unique case (tx_state_q)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_q[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge CoreClock or posedge Reset) begin
    if (Reset) begin
      baud_div_q    <= DEFAULT_BAUD_DIV;
      tx_overflow_q <= 1'b0;
      tx_state_q    <= IDLE;
      baud_cnt_q    <= '0;
      bit_idx_q     <= '0;
      shift_q       <= '0;
      tx_q          <= 1'b1;
    end else begin
      baud_div_q    <= baud_div_d;
      tx_overflow_q <= tx_overflow_d;
      tx_state_q    <= tx_state_d;
      baud_cnt_q    <= baud_cnt_d;
      bit_idx_q     <= bit_idx_d;
      shift_q       <= shift_d;
      tx_q          <= tx_d;
    end
  end

  assign UartTx = tx_q;

`ifdef MM_UART_RX_EN
  logic              rx_s1_q, rx_s2_q;
  uart_rx_state_t    rx_state_q, rx_state_d;
  logic [BAUD_W-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]        rx_bit_q, rx_bit_d;
  logic [BYTE_W-1:0] rx_shift_q, rx_shift_d;
  logic [BYTE_W-1:0] rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic              rx_overrun_q, rx_overrun_d;
  logic              rd_rxdata, rx_commit;
  logic [BAUD_W:0]   rx_half;

  // Receiver; the first wait is shortened by 2 to offset synchroniser and detect latency.
  always_comb begin
    rd_rxdata    = ReadAssert && (reg_sel == REG_RXDATA);
    rx_half      = (17'(baud_div_q) + 17'd1) >> 1;
    rx_state_d   = rx_state_q;
    rx_cnt_d     = rx_cnt_q;
    rx_bit_d     = rx_bit_q;
    rx_shift_d   = rx_shift_q;
    rx_data_d    = rx_data_q;
    rx_valid_d   = rx_valid_q;
    rx_overrun_d = rx_overrun_q;
    rx_commit    = 1'b0;
    unique case (rx_state_q)
      RX_IDLE: begin
        if (!rx_s2_q) begin
          rx_state_d = RX_START;
          rx_cnt_d   = (rx_half > 17'd2) ? 16'(rx_half - 17'd2) : '0;
        end
      end
      RX_START: begin
        if (rx_cnt_q == '0) begin
          rx_cnt_d   = baud_div_q;
          rx_bit_d   = 3'd0;
          rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q - 16'd1;
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == '0) begin
          rx_cnt_d   = baud_div_q;
          rx_shift_d = {rx_s2_q, rx_shift_q[BYTE_W-1:1]};
          rx_bit_d   = rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
        end else begin
          rx_cnt_d = rx_cnt_q - 16'd1;
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == '0) begin
          rx_state_d = RX_IDLE;
          rx_commit  = rx_s2_q;
        end else begin
          rx_cnt_d = rx_cnt_q - 16'd1;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase

    if (rd_rxdata) rx_valid_d = 1'b0;
    if (wr_status && DataWriteBus[ST_RX_OVERRUN]) rx_overrun_d = 1'b0;
    if (rx_commit) begin
      rx_data_d  = rx_shift_q;
      rx_valid_d = 1'b1;
      if (rx_valid_q && !rd_rxdata) rx_overrun_d = 1'b1;
    end
  end

  always_ff @(posedge CoreClock or posedge Reset) begin
    if (Reset) begin
      rx_s1_q      <= 1'b1;
      rx_s2_q      <= 1'b1;
      rx_state_q   <= RX_IDLE;
      rx_cnt_q     <= '0;
      rx_bit_q     <= '0;
      rx_shift_q   <= '0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      rx_overrun_q <= 1'b0;
    end else begin
      rx_s1_q      <= UartRx;
      rx_s2_q      <= rx_s1_q;
      rx_state_q   <= rx_state_d;
      rx_cnt_q     <= rx_cnt_d;
      rx_bit_q     <= rx_bit_d;
      rx_shift_q   <= rx_shift_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      rx_overrun_q <= rx_overrun_d;
    end
  end

  assign rx_valid   = rx_valid_q;
  assign rx_overrun = rx_overrun_q;
  assign rx_byte    = rx_data_q;

  logic unused_ok;
  assign unused_ok = ^{AddressBus[31:4], AddressBus[1:0], DataWriteBus[31:16]};
`else
  assign rx_valid   = 1'b0;
  assign rx_overrun = 1'b0;
  assign rx_byte    = '0;

  logic unused_ok;
  assign unused_ok = ^{AddressBus[31:4], AddressBus[1:0], DataWriteBus[31:16], ReadAssert};
`endif

  // Zero-wait-state read mux, independent of ReadAssert.
  always_comb begin
    status             = '0;
    status.tx_full     = fifo_full;
    status.tx_empty    = fifo_empty;
    status.tx_busy     = (tx_state_q != IDLE);
    status.rx_valid    = rx_valid;
    status.rx_overrun  = rx_overrun;
    status.tx_overflow = tx_overflow_q;
    status.tx_count    = 8'(fifo_count);
    unique case (reg_sel)
      REG_TXDATA:  DataReadBus = '0;
      REG_STATUS:  DataReadBus = status;
      REG_BAUDDIV: DataReadBus = 32'(baud_div_q);
      default:     DataReadBus = 32'(rx_byte);
    endcase
  end

endmodule
